// File: rtl/alu_seq_exec.sv
// alu_seq_exec: multi-cycle EX-stage execute unit.
// Accepts a 4-bit ALU opcode with operands over a valid/ready handshake.
// Logic, arithmetic and compare ops finish in one cycle. Shifts run
// iteratively, moving one bit per cycle. Results are returned over a
// valid/ready handshake with backpressure.
// Ports:
//   clk, rst_n             clock, asynchronous active-low reset
//   in_valid / in_ready    request handshake
//   alu_opcode, op_a, op_b request payload (shift amount = op_b[SHAMT_W-1:0])
//   out_valid / out_ready  result handshake
//   result, zero           result value and result==0 flag
//   illegal_op             accepted opcode was not a defined operation
module alu_seq_exec #(
   parameter  int unsigned WIDTH   = 32,
   localparam int unsigned SHAMT_W = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [3:0]       alu_opcode,
   input  logic [WIDTH-1:0] op_a,
   input  logic [WIDTH-1:0] op_b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             zero,
   output logic             illegal_op
);

   localparam logic [3:0] OP_SLT  = 4'b0000;
   localparam logic [3:0] OP_ADD  = 4'b0001;
   localparam logic [3:0] OP_SUB  = 4'b0010;
   localparam logic [3:0] OP_AND  = 4'b0011;
   localparam logic [3:0] OP_OR   = 4'b0100;
   localparam logic [3:0] OP_SLL  = 4'b0101;
   localparam logic [3:0] OP_SRL  = 4'b0110;
   localparam logic [3:0] OP_XOR  = 4'b0111;
   localparam logic [3:0] OP_SRA  = 4'b1010;
   localparam logic [3:0] OP_SLTU = 4'b1011;

   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

   state_t             state_q, state_d;
   logic               in_ready_d, out_valid_d, zero_d, illegal_d;
   logic [WIDTH-1:0]   result_d;
   logic [WIDTH-1:0]   work_q, work_d;
   logic [SHAMT_W-1:0] cnt_q, cnt_d;
   logic [3:0]         sop_q, sop_d;

   logic [SHAMT_W-1:0] shamt;
   logic               is_shift;
   logic               legal;
   logic [WIDTH-1:0]   alu_res;
   logic [WIDTH-1:0]   shift1;

   assign shamt    = op_b[SHAMT_W-1:0];
   assign is_shift = (alu_opcode == OP_SLL) || (alu_opcode == OP_SRL) ||
                     (alu_opcode == OP_SRA);

   // Single-cycle datapath; a shift only lands here when its amount is zero.
   always_comb begin
      legal   = 1'b1;
      alu_res = '0;
      case (alu_opcode)
         OP_SLT:  alu_res = ($signed(op_a) < $signed(op_b)) ? WIDTH'(1) : '0;
         OP_SLTU: alu_res = (op_a < op_b) ? WIDTH'(1) : '0;
         OP_ADD:  alu_res = op_a + op_b;
         OP_SUB:  alu_res = op_a - op_b;
         OP_AND:  alu_res = op_a & op_b;
         OP_OR:   alu_res = op_a | op_b;
         OP_XOR:  alu_res = op_a ^ op_b;
         OP_SLL, OP_SRL, OP_SRA: alu_res = op_a;
         default: begin
            legal   = 1'b0;
            alu_res = '0;
         end
      endcase
   end

   // One-bit step of the iterative shifter.
   always_comb begin
      shift1 = work_q;
      case (sop_q)
         OP_SLL:  shift1 = {work_q[WIDTH-2:0], 1'b0};
         OP_SRL:  shift1 = {1'b0, work_q[WIDTH-1:1]};
         OP_SRA:  shift1 = {work_q[WIDTH-1], work_q[WIDTH-1:1]};
         default: shift1 = work_q;
      endcase
   end

   // Next-state and next-output logic.
   always_comb begin
      state_d     = state_q;
      in_ready_d  = in_ready;
      out_valid_d = out_valid;
      result_d    = result;
      zero_d      = zero;
      illegal_d   = illegal_op;
      work_d      = work_q;
      cnt_d       = cnt_q;
      sop_d       = sop_q;
      case (state_q)
         IDLE: begin
            if (in_valid) begin
               in_ready_d = 1'b0;
               if (is_shift && (shamt != '0)) begin
                  work_d  = op_a;
                  cnt_d   = shamt;
                  sop_d   = alu_opcode;
                  state_d = SHIFT;
               end else begin
                  result_d    = alu_res;
                  zero_d      = (alu_res == '0);
                  illegal_d   = ~legal;
                  out_valid_d = 1'b1;
                  state_d     = DONE;
               end
            end
         end
         SHIFT: begin
            work_d = shift1;
            cnt_d  = cnt_q - SHAMT_W'(1);
            if (cnt_q == SHAMT_W'(1)) begin
               result_d    = shift1;
               zero_d      = (shift1 == '0);
               illegal_d   = 1'b0;
               out_valid_d = 1'b1;
               state_d     = DONE;
            end
         end
         DONE: begin
            // Release only; a new request waits for the following edge.
            if (out_ready) begin
               out_valid_d = 1'b0;
               in_ready_d  = 1'b1;
               state_d     = IDLE;
            end
         end
         default: begin
            state_d     = IDLE;
            in_ready_d  = 1'b1;
            out_valid_d = 1'b0;
         end
      endcase
   end

   // State and output registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         in_ready   <= 1'b1;
         out_valid  <= 1'b0;
         result     <= '0;
         zero       <= 1'b1;
         illegal_op <= 1'b0;
         work_q     <= '0;
         cnt_q      <= '0;
         sop_q      <= '0;
      end else begin
         state_q    <= state_d;
         in_ready   <= in_ready_d;
         out_valid  <= out_valid_d;
         result     <= result_d;
         zero       <= zero_d;
         illegal_op <= illegal_d;
         work_q     <= work_d;
         cnt_q      <= cnt_d;
         sop_q      <= sop_d;
      end
   end

endmodule

// File: tb/tb_alu_seq_exec.sv
// Directed testbench for alu_seq_exec with hand-computed expected values.
module tb_alu_seq_exec;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [3:0]  alu_opcode;
   logic [31:0] op_a;
   logic [31:0] op_b;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] result;
   logic        zero;
   logic        illegal_op;

   int total = 0;
   int bad   = 0;

   alu_seq_exec #(.WIDTH(32)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .alu_opcode (alu_opcode),
      .op_a       (op_a),
      .op_b       (op_b),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .result     (result),
      .zero       (zero),
      .illegal_op (illegal_op)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp)
      else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Issue one request, wait for the result, check it, hold it for `hold`
   // cycles of backpressure, then release it.
   task automatic run_op(input string tag, input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp_res,
                         input logic exp_zero, input logic exp_ill,
                         input int exp_lat, input int hold);
      int lat;
      logic ir_seen;
      in_valid   = 1'b1;
      alu_opcode = op;
      op_a       = a;
      op_b       = b;
      tick();
      in_valid   = 1'b0;
      op_a       = ~a;
      op_b       = ~b;
      lat        = 0;
      ir_seen    = 1'b0;
      while (!out_valid && lat < 100) begin
         if (in_ready) ir_seen = 1'b1;
         tick();
         lat++;
      end
      chk({tag, "_lat"}, 32'(lat), 32'(exp_lat));
      chk({tag, "_busy_ready"}, 32'(ir_seen), 32'd0);
      chk({tag, "_valid"}, 32'(out_valid), 32'd1);
      chk({tag, "_result"}, result, exp_res);
      chk({tag, "_zero"}, 32'(zero), 32'(exp_zero));
      chk({tag, "_illegal"}, 32'(illegal_op), 32'(exp_ill));
      chk({tag, "_done_ready"}, 32'(in_ready), 32'd0);
      for (int i = 0; i < hold; i++) begin
         tick();
         chk({tag, "_hold_valid"}, 32'(out_valid), 32'd1);
         chk({tag, "_hold_result"}, result, exp_res);
         chk({tag, "_hold_ready"}, 32'(in_ready), 32'd0);
      end
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      chk({tag, "_rel_valid"}, 32'(out_valid), 32'd0);
      chk({tag, "_rel_ready"}, 32'(in_ready), 32'd1);
   endtask

   initial begin
      int stale;
      rst_n      = 1'b0;
      in_valid   = 1'b0;
      alu_opcode = 4'h0;
      op_a       = '0;
      op_b       = '0;
      out_ready  = 1'b0;
      #12;
      chk("rst_in_ready", 32'(in_ready), 32'd1);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_result", result, 32'h0);
      chk("rst_zero", 32'(zero), 32'd1);
      chk("rst_illegal", 32'(illegal_op), 32'd0);
      tick();
      rst_n = 1'b1;
      tick();

      run_op("add",  4'b0001, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 1'b0, 1'b0, 0, 0);
      run_op("sub",  4'b0010, 32'd5, 32'd5, 32'h0, 1'b1, 1'b0, 0, 0);
      run_op("slt",  4'b0000, 32'hFFFF_FFFF, 32'h1, 32'h1, 1'b0, 1'b0, 0, 0);
      run_op("sltu", 4'b1011, 32'hFFFF_FFFF, 32'h1, 32'h0, 1'b1, 1'b0, 0, 0);
      run_op("and",  4'b0011, 32'h0000_F0F0, 32'h0000_FF00, 32'h0000_F000, 1'b0, 1'b0, 0, 0);
      run_op("or",   4'b0100, 32'h0000_F0F0, 32'h0000_FF00, 32'h0000_FFF0, 1'b0, 1'b0, 0, 0);
      run_op("sra",  4'b1010, 32'h8000_0000, 32'h0000_001F, 32'hFFFF_FFFF, 1'b0, 1'b0, 31, 0);
      run_op("sll",  4'b0101, 32'h0000_0001, 32'h0000_0024, 32'h0000_0010, 1'b0, 1'b0, 4, 0);
      run_op("srl3", 4'b0110, 32'h8000_0000, 32'h0000_0003, 32'h1000_0000, 1'b0, 1'b0, 3, 0);
      run_op("xor",  4'b0111, 32'hF0F0_F0F0, 32'hFFFF_0000, 32'h0F0F_F0F0, 1'b0, 1'b0, 0, 5);
      run_op("ill",  4'b1111, 32'h1234_5678, 32'h1111_1111, 32'h0, 1'b1, 1'b1, 0, 0);
      run_op("srl0", 4'b0110, 32'h1234_5678, 32'h0000_0020, 32'h1234_5678, 1'b0, 1'b0, 0, 0);

      // Abort a long shift with reset partway through.
      in_valid   = 1'b1;
      alu_opcode = 4'b0110;
      op_a       = 32'hFFFF_0000;
      op_b       = 32'd20;
      tick();
      in_valid   = 1'b0;
      repeat (7) tick();
      chk("mid_busy", 32'(in_ready), 32'd0);
      rst_n = 1'b0;
      #1;
      chk("abort_valid", 32'(out_valid), 32'd0);
      chk("abort_ready", 32'(in_ready), 32'd1);
      tick();
      rst_n = 1'b1;
      stale = 0;
      for (int i = 0; i < 25; i++) begin
         tick();
         if (out_valid || !in_ready) stale++;
      end
      chk("no_stale", 32'(stale), 32'd0);
      run_op("add2", 4'b0001, 32'h0000_0010, 32'h0000_0020, 32'h0000_0030, 1'b0, 1'b0, 0, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
